// File: rtl/player_ctrl.sv
// Player-ship controller: position, lives, level, shot rate-limiting and game phase.
// Buttons are level inputs; shoot is edge-detected and doubles as the resume button.
module player_ctrl #(
    parameter int unsigned pos_width_p    = 10,
    parameter int unsigned screen_width_p = 640,
    parameter int unsigned ship_width_p   = 32,
    parameter int unsigned step_p         = 4,
    parameter int unsigned init_lives_p   = 3,
    parameter int unsigned max_lives_p    = 5,
    parameter int unsigned bonus_every_p  = 2,
    parameter int unsigned num_levels_p   = 8,
    parameter int unsigned cooldown_p     = 8,
    parameter int unsigned flash_div_p    = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 frame_tick_i,
    input  logic                                 move_left_i,
    input  logic                                 move_right_i,
    input  logic                                 shoot_i,
    input  logic                                 hit_i,
    input  logic                                 level_clear_i,
    output logic [pos_width_p-1:0]               pos_left_o,
    output logic [pos_width_p-1:0]               pos_right_o,
    output logic [$clog2(max_lives_p+1)-1:0]     lives_o,
    output logic [$clog2(num_levels_p+1)-1:0]    level_o,
    output logic [6:0]                           state_o,
    output logic                                 alive_o,
    output logic                                 shot_fire_o,
    output logic                                 flash_o,
    output logic                                 level_beat_o,
    output logic                                 game_over_o,
    output logic                                 game_won_o
);

    localparam int unsigned lives_w_lp = $clog2(max_lives_p + 1);
    localparam int unsigned level_w_lp = $clog2(num_levels_p + 1);
    localparam int unsigned cool_w_lp  = $clog2(cooldown_p + 1);
    localparam int unsigned flash_w_lp = $clog2(flash_div_p + 1);

    localparam logic [pos_width_p:0]   max_pos_lp    = (pos_width_p+1)'(screen_width_p - ship_width_p);
    localparam logic [pos_width_p:0]   step_lp       = (pos_width_p+1)'(step_p);
    localparam logic [pos_width_p-1:0] center_lp     = pos_width_p'((screen_width_p - ship_width_p) / 2);
    localparam logic [pos_width_p-1:0] ship_m1_lp    = pos_width_p'(ship_width_p - 1);
    localparam logic [lives_w_lp-1:0]  init_lives_lp = lives_w_lp'(init_lives_p);
    localparam logic [lives_w_lp-1:0]  max_lives_lp  = lives_w_lp'(max_lives_p);
    localparam logic [level_w_lp-1:0]  last_level_lp = level_w_lp'(num_levels_p);
    localparam logic [cool_w_lp-1:0]   cooldown_lp   = cool_w_lp'(cooldown_p);
    localparam logic [flash_w_lp-1:0]  flash_last_lp = flash_w_lp'(flash_div_p - 1);

    typedef enum logic [6:0] {
        ST_STILL    = 7'b0000001,
        ST_LEFT     = 7'b0000010,
        ST_RIGHT    = 7'b0000100,
        ST_HIT      = 7'b0001000,
        ST_DEAD     = 7'b0010000,
        ST_LVL_DONE = 7'b0100000,
        ST_WON      = 7'b1000000
    } state_e;

    state_e                  state_q, state_d;
    logic [pos_width_p-1:0]  pos_q, pos_d;
    logic [lives_w_lp-1:0]   lives_q, lives_d;
    logic [level_w_lp-1:0]   level_q, level_d;
    logic [cool_w_lp-1:0]    cool_q, cool_d;
    logic [flash_w_lp-1:0]   flash_cnt_q, flash_cnt_d;
    logic                    flash_q, flash_d;
    logic                    shoot_q;
    logic                    shot_fire_q, shot_fire_d;
    logic                    level_beat_q, level_beat_d;
    logic                    shoot_rise_s;
    logic [pos_width_p:0]    pos_ext_s, left_ext_s, right_ext_s;

    assign shoot_rise_s = shoot_i & ~shoot_q;

    // Saturating one-step moves, evaluated one bit wider so nothing wraps.
    always_comb begin
        pos_ext_s   = {1'b0, pos_q};
        left_ext_s  = (pos_ext_s < step_lp) ? {(pos_width_p+1){1'b0}} : (pos_ext_s - step_lp);
        right_ext_s = pos_ext_s + step_lp;
        if (right_ext_s > max_pos_lp) begin
            right_ext_s = max_pos_lp;
        end else begin
            right_ext_s = pos_ext_s + step_lp;
        end
    end

    // Next-state logic for phase, position, lives, level, cooldown and pulses.
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        lives_d      = lives_q;
        level_d      = level_q;
        shot_fire_d  = 1'b0;
        level_beat_d = 1'b0;
        if (frame_tick_i && (cool_q != cool_w_lp'(0))) begin
            cool_d = cool_q - cool_w_lp'(1);
        end else begin
            cool_d = cool_q;
        end

        case (state_q)
            ST_STILL, ST_LEFT, ST_RIGHT: begin
                if (frame_tick_i && (state_q == ST_LEFT)) begin
                    pos_d = pos_width_p'(left_ext_s);
                end else if (frame_tick_i && (state_q == ST_RIGHT)) begin
                    pos_d = pos_width_p'(right_ext_s);
                end else begin
                    pos_d = pos_q;
                end
                if (shoot_rise_s && (cool_q == cool_w_lp'(0))) begin
                    shot_fire_d = 1'b1;
                    cool_d      = cooldown_lp;
                end else begin
                    shot_fire_d = 1'b0;
                end
                // A level clear takes priority over a simultaneous hit.
                if (level_clear_i) begin
                    level_beat_d = 1'b1;
                    state_d      = (level_q == last_level_lp) ? ST_WON : ST_LVL_DONE;
                    if (((32'(level_q) % bonus_every_p) == 32'd0) && (lives_q < max_lives_lp)) begin
                        lives_d = lives_q + lives_w_lp'(1);
                    end else begin
                        lives_d = lives_q;
                    end
                end else if (hit_i) begin
                    if (lives_q > lives_w_lp'(1)) begin
                        lives_d = lives_q - lives_w_lp'(1);
                        state_d = ST_HIT;
                    end else begin
                        lives_d = lives_w_lp'(0);
                        state_d = ST_DEAD;
                    end
                end else if (move_left_i && !move_right_i) begin
                    state_d = ST_LEFT;
                end else if (move_right_i && !move_left_i) begin
                    state_d = ST_RIGHT;
                end else begin
                    state_d = ST_STILL;
                end
            end
            ST_HIT: begin
                if (shoot_rise_s) begin
                    state_d = ST_STILL;
                end else begin
                    state_d = ST_HIT;
                end
            end
            ST_LVL_DONE: begin
                if (shoot_rise_s) begin
                    level_d = level_q + level_w_lp'(1);
                    pos_d   = center_lp;
                    cool_d  = cool_w_lp'(0);
                    state_d = ST_STILL;
                end else begin
                    state_d = ST_LVL_DONE;
                end
            end
            ST_DEAD: begin
                if (shoot_rise_s) begin
                    lives_d = init_lives_lp;
                    level_d = level_w_lp'(1);
                    pos_d   = center_lp;
                    state_d = ST_STILL;
                end else begin
                    state_d = ST_DEAD;
                end
            end
            ST_WON: begin
                state_d = ST_WON;
            end
            default: begin
                state_d = ST_STILL;
            end
        endcase
    end

    // Ship visibility: blinks during the hit pause, starting dark on entry.
    always_comb begin
        flash_cnt_d = flash_cnt_q;
        flash_d     = flash_q;
        if ((state_d == ST_HIT) && (state_q != ST_HIT)) begin
            flash_cnt_d = flash_w_lp'(0);
            flash_d     = 1'b0;
        end else if (state_d == ST_HIT) begin
            if (frame_tick_i && (flash_cnt_q == flash_last_lp)) begin
                flash_cnt_d = flash_w_lp'(0);
                flash_d     = ~flash_q;
            end else if (frame_tick_i) begin
                flash_cnt_d = flash_cnt_q + flash_w_lp'(1);
                flash_d     = flash_q;
            end else begin
                flash_d     = flash_q;
            end
        end else begin
            flash_d = (state_d != ST_DEAD) && (state_d != ST_WON);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_STILL;
            pos_q        <= center_lp;
            lives_q      <= init_lives_lp;
            level_q      <= level_w_lp'(1);
            cool_q       <= cool_w_lp'(0);
            flash_cnt_q  <= flash_w_lp'(0);
            flash_q      <= 1'b1;
            shoot_q      <= 1'b1;
            shot_fire_q  <= 1'b0;
            level_beat_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            cool_q       <= cool_d;
            flash_cnt_q  <= flash_cnt_d;
            flash_q      <= flash_d;
            shoot_q      <= shoot_i;
            shot_fire_q  <= shot_fire_d;
            level_beat_q <= level_beat_d;
        end
    end

    assign pos_left_o   = pos_q;
    assign pos_right_o  = pos_q + ship_m1_lp;
    assign lives_o      = lives_q;
    assign level_o      = level_q;
    assign state_o      = state_q;
    assign alive_o      = (state_q == ST_STILL) || (state_q == ST_LEFT) || (state_q == ST_RIGHT);
    assign shot_fire_o  = shot_fire_q;
    assign flash_o      = flash_q;
    assign level_beat_o = level_beat_q;
    assign game_over_o  = (state_q == ST_DEAD);
    assign game_won_o   = (state_q == ST_WON);

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: directed scenarios plus random traffic,
// all compared every cycle against a phase-level reference model.
module tb_player_ctrl;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1, frame_tick_i = 1'b0, move_left_i = 1'b0, move_right_i = 1'b0;
    logic       shoot_i = 1'b0, hit_i = 1'b0, level_clear_i = 1'b0;
    logic [9:0] pos_left_o, pos_right_o;
    logic [2:0] lives_o;
    logic [3:0] level_o;
    logic [6:0] state_o;
    logic       alive_o, shot_fire_o, flash_o, level_beat_o, game_over_o, game_won_o;

    int checks = 0, failures = 0, fires = 0, mark = 0;

    // Reference model: phase code 0..6 = STILL LEFT RIGHT HIT DEAD LVL_DONE WON
    int m_st, m_pos, m_lives, m_level, m_since_shot, m_hit_ticks;
    bit m_sh_prev, m_fire, m_beat;

    player_ctrl dut (
        .clk_i(clk), .reset_i(reset_i), .frame_tick_i(frame_tick_i),
        .move_left_i(move_left_i), .move_right_i(move_right_i), .shoot_i(shoot_i),
        .hit_i(hit_i), .level_clear_i(level_clear_i),
        .pos_left_o(pos_left_o), .pos_right_o(pos_right_o), .lives_o(lives_o),
        .level_o(level_o), .state_o(state_o), .alive_o(alive_o),
        .shot_fire_o(shot_fire_o), .flash_o(flash_o), .level_beat_o(level_beat_o),
        .game_over_o(game_over_o), .game_won_o(game_won_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit ft, l, r, s, h, c, rst);
        bit rise;
        int nst;
        rise = s && !m_sh_prev;
        m_sh_prev = s;
        m_fire = 0;
        m_beat = 0;
        if (rst) begin
            m_st = 0; m_pos = 304; m_lives = 3; m_level = 1;
            m_since_shot = 8; m_hit_ticks = 0; m_sh_prev = 1;
            return;
        end
        nst = m_st;
        if (m_st <= 2) begin
            if (ft && m_st == 1) m_pos = (m_pos > 4) ? m_pos - 4 : 0;
            if (ft && m_st == 2) m_pos = (m_pos + 4 < 608) ? m_pos + 4 : 608;
            m_fire = rise && (m_since_shot >= 8);
            if (level_clear_i) begin
                m_beat = 1;
                if (m_level % 2 == 0 && m_lives < 5) m_lives++;
                nst = (m_level == 8) ? 6 : 5;
            end else if (h) begin
                m_lives--;
                nst = (m_lives == 0) ? 4 : 3;
            end else begin
                nst = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
            end
        end else if (rise) begin
            if (m_st == 3) nst = 0;
            if (m_st == 5) begin m_level++; m_pos = 304; m_since_shot = 8; nst = 0; end
            if (m_st == 4) begin m_lives = 3; m_level = 1; m_pos = 304; nst = 0; end
        end
        if (m_fire) m_since_shot = 0;
        else if (ft && m_since_shot < 8 && !(m_st == 5 && nst == 0)) m_since_shot++;
        if (nst == 3 && m_st != 3) m_hit_ticks = 0;
        else if (nst == 3 && ft) m_hit_ticks++;
        m_st = nst;
    endtask

    function automatic bit exp_flash();
        if (m_st == 3) return ((m_hit_ticks / 4) % 2) == 1;
        return (m_st != 4) && (m_st != 6);
    endfunction

    task automatic step(input bit ft, l, r, s, h, c, rst);
        frame_tick_i = ft; move_left_i = l; move_right_i = r; shoot_i = s;
        hit_i = h; level_clear_i = c; reset_i = rst;
        @(posedge clk);
        model(ft, l, r, s, h, c, rst);
        #1;
        if (shot_fire_o === 1'b1) fires++;
        chk("state", 32'(state_o), 32'(1) << m_st);
        chk("pos_left", 32'(pos_left_o), 32'(m_pos));
        chk("pos_right", 32'(pos_right_o), 32'(m_pos + 31));
        chk("lives", 32'(lives_o), 32'(m_lives));
        chk("level", 32'(level_o), 32'(m_level));
        chk("alive", 32'(alive_o), 32'(m_st <= 2));
        chk("shot_fire", 32'(shot_fire_o), 32'(m_fire));
        chk("level_beat", 32'(level_beat_o), 32'(m_beat));
        chk("flash", 32'(flash_o), 32'(exp_flash()));
        chk("game_over", 32'(game_over_o), 32'(m_st == 4));
        chk("game_won", 32'(game_won_o), 32'(m_st == 6));
    endtask

    task automatic frames(input int n, input bit l, r, s);
        for (int i = 0; i < n; i++) begin
            step(0, l, r, s, 0, 0, 0);
            step(1, l, r, s, 0, 0, 0);
            step(0, l, r, s, 0, 0, 0);
        end
    endtask

    task automatic press();
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_sh_prev = 1;
        // Reset with shoot held: no shot on release of reset
        step(0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 1);
        chk("reset_pos", 32'(pos_left_o), 32'd304);
        chk("reset_state", 32'(state_o), 32'd1);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("no_fire_held_through_reset", 32'(shot_fire_o), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Right saturation, both buttons, left saturation
        frames(100, 0, 1, 0);
        chk("right_sat_left", 32'(pos_left_o), 32'd608);
        chk("right_sat_right", 32'(pos_right_o), 32'd639);
        frames(10, 1, 1, 0);
        chk("both_state", 32'(state_o), 32'd1);
        chk("both_pos", 32'(pos_left_o), 32'd608);
        frames(160, 1, 0, 0);
        chk("left_sat", 32'(pos_left_o), 32'd0);
        frames(2, 0, 0, 0);

        // Cooldown: presses at 0, +3 and +9 frame ticks
        mark = fires;
        press();
        frames(3, 0, 0, 0);
        press();
        frames(6, 0, 0, 0);
        press();
        frames(2, 0, 0, 0);
        chk("cooldown_shots", 32'(fires - mark), 32'd2);
        frames(10, 0, 0, 0);
        mark = fires;
        frames(20, 0, 0, 1);
        chk("held_fires_once", 32'(fires - mark), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);

        // Three hits down to DEAD, then restart
        step(0, 0, 0, 0, 1, 0, 0);
        chk("hit1_lives", 32'(lives_o), 32'd2);
        chk("hit1_state", 32'(state_o), 32'd8);
        frames(6, 0, 0, 0);
        press();
        step(0, 0, 0, 0, 1, 0, 0);
        chk("hit2_lives", 32'(lives_o), 32'd1);
        frames(9, 1, 0, 0);
        press();
        step(0, 0, 0, 0, 1, 0, 0);
        chk("hit3_lives", 32'(lives_o), 32'd0);
        chk("hit3_over", 32'(game_over_o), 32'd1);
        frames(2, 0, 0, 0);
        press();
        chk("restart_lives", 32'(lives_o), 32'd3);
        chk("restart_pos", 32'(pos_left_o), 32'd304);

        // Level progression up to the win
        step(0, 0, 0, 0, 0, 1, 0);
        chk("clear1_state", 32'(state_o), 32'd32);
        press();
        step(0, 0, 0, 0, 0, 1, 0);
        chk("clear2_beat", 32'(level_beat_o), 32'd1);
        chk("clear2_lives", 32'(lives_o), 32'd4);
        press();
        chk("resume_level", 32'(level_o), 32'd3);
        for (int lv = 3; lv < 8; lv++) begin
            frames(1, 0, 1, 0);
            step(0, 0, 0, 0, 0, 1, 0);
            press();
        end
        chk("capped_lives", 32'(lives_o), 32'd5);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("won", 32'(game_won_o), 32'd1);
        press();
        frames(2, 0, 0, 0);
        chk("won_terminal", 32'(state_o), 32'd64);

        // Simultaneous hit + clear, then reset during hit flashing
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1, 0);
        chk("simul_state", 32'(state_o), 32'd32);
        chk("simul_lives", 32'(lives_o), 32'd3);
        press();
        step(0, 0, 0, 0, 1, 0, 0);
        frames(6, 0, 0, 0);
        chk("mid_flash", 32'(flash_o), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("rst_state", 32'(state_o), 32'd1);
        chk("rst_lives", 32'(lives_o), 32'd3);
        chk("rst_level", 32'(level_o), 32'd1);
        chk("rst_pos", 32'(pos_left_o), 32'd304);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 3) == 0, ($urandom % 2) == 1, ($urandom % 2) == 1,
                 ($urandom % 4) == 0, ($urandom % 40) == 0, ($urandom % 60) == 0,
                 ($urandom % 700) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
